// File: rtl/code_expander.sv
// Dictionary-based instruction decompressor sitting between the CPU memory port and mem.
// Code-window fetches are expanded from 16-bit indices via an internal dictionary RAM.
module code_expander #(
  parameter logic [31:0] CODE_BASE    = 32'h0000_0000,
  parameter logic [31:0] CODE_SIZE    = 32'h0001_0000,
  parameter logic [31:0] CMP_BASE     = 32'h0008_0000,
  parameter logic [31:0] DICT_BASE    = 32'h2000_0000,
  parameter int unsigned DICT_ENTRIES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int          AW        = (DICT_ENTRIES > 1) ? $clog2(DICT_ENTRIES) : 1;
  localparam logic [31:0] DictLimit = 32'(DICT_ENTRIES);
  localparam logic [31:0] DictSpan  = 32'(DICT_ENTRIES) << 2;
  localparam logic [31:0] NopInstr  = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, MEM, DICT, RESP} state_e;
  typedef enum logic [1:0] {K_PASS, K_FETCH, K_DICT} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic        sel_q, sel_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic [3:0]  memWstrb_q, memWstrb_d;
  logic [31:0] dWdata_q, dWdata_d;
  logic [3:0]  dWstrb_q, dWstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ramSel_q, ramSel_d;
  logic        bufValid_q, bufValid_d;
  logic [31:0] bufTag_q, bufTag_d;
  logic [31:0] bufWord_q, bufWord_d;

  logic [31:0] dict_q [DICT_ENTRIES];
  logic [31:0] ramRd_q;

  logic [31:0] codeOff, dictOff, cwAddr;
  logic        isFetch, isDict, bufHit;
  logic [15:0] hitIndex, memIndex, dictEntry;
  logic [AW-1:0] ramIdx;

  // Offsets wrap modulo 2^32, so a single unsigned compare is the full range check.
  assign codeOff   = cpu_addr - CODE_BASE;
  assign dictOff   = cpu_addr - DICT_BASE;
  assign isFetch   = cpu_instr && (cpu_wstrb == 4'h0) && (codeOff < CODE_SIZE);
  assign isDict    = !isFetch && (dictOff < DictSpan);
  assign cwAddr    = CMP_BASE + {1'b0, codeOff[31:3], 2'b00};
  assign bufHit    = bufValid_q && (bufTag_q == cwAddr);
  assign hitIndex  = codeOff[2] ? bufWord_q[31:16] : bufWord_q[15:0];
  assign memIndex  = sel_q ? mem_rdata[31:16] : mem_rdata[15:0];
  assign dictEntry = 16'(dictOff[AW+1:2]);
  assign ramIdx    = idx_q[AW-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cpu_valid) begin
        if (isFetch)     state_d = bufHit ? DICT : MEM;
        else if (isDict) state_d = DICT;
        else             state_d = MEM;
      end
      MEM:  if (mem_ready) state_d = (kind_q == K_FETCH) ? DICT : RESP;
      DICT: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid = (state_q == MEM);
    cpu_ready = (state_q == RESP);
  end

  always_comb begin
    kind_d     = kind_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWstrb_d = memWstrb_q;
    dWdata_d   = dWdata_q;
    dWstrb_d   = dWstrb_q;
    rdata_d    = rdata_q;
    ramSel_d   = ramSel_q;
    bufValid_d = bufValid_q;
    bufTag_d   = bufTag_q;
    bufWord_d  = bufWord_q;
    unique case (state_q)
      IDLE: if (cpu_valid) begin
        sel_d = codeOff[2];
        if (isFetch) begin
          kind_d     = K_FETCH;
          memAddr_d  = cwAddr;
          memWdata_d = 32'h0;
          memWstrb_d = 4'h0;
          if (bufHit) idx_d = hitIndex;
        end else if (isDict) begin
          kind_d   = K_DICT;
          idx_d    = dictEntry;
          dWdata_d = cpu_wdata;
          dWstrb_d = cpu_wstrb;
        end else begin
          kind_d     = K_PASS;
          memAddr_d  = cpu_addr;
          memWdata_d = cpu_wdata;
          memWstrb_d = cpu_wstrb;
          // A write landing on the buffered compressed word makes the buffer stale.
          if ((cpu_wstrb != 4'h0) && (cpu_addr[31:2] == bufTag_q[31:2])) bufValid_d = 1'b0;
        end
      end
      MEM: if (mem_ready) begin
        if (kind_q == K_FETCH) begin
          bufValid_d = 1'b1;
          bufTag_d   = memAddr_q;
          bufWord_d  = mem_rdata;
          idx_d      = memIndex;
        end else begin
          rdata_d  = mem_rdata;
          ramSel_d = 1'b0;
        end
      end
      DICT: begin
        if ({16'h0, idx_q} < DictLimit) begin
          ramSel_d = 1'b1;
        end else begin
          ramSel_d = 1'b0;
          rdata_d  = NopInstr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kind_q     <= K_PASS;
      sel_q      <= 1'b0;
      idx_q      <= 16'h0;
      memAddr_q  <= 32'h0;
      memWdata_q <= 32'h0;
      memWstrb_q <= 4'h0;
      dWdata_q   <= 32'h0;
      dWstrb_q   <= 4'h0;
      rdata_q    <= 32'h0;
      ramSel_q   <= 1'b0;
      bufValid_q <= 1'b0;
      bufTag_q   <= 32'h0;
      bufWord_q  <= 32'h0;
    end else begin
      kind_q     <= kind_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWstrb_q <= memWstrb_d;
      dWdata_q   <= dWdata_d;
      dWstrb_q   <= dWstrb_d;
      rdata_q    <= rdata_d;
      ramSel_q   <= ramSel_d;
      bufValid_q <= bufValid_d;
      bufTag_q   <= bufTag_d;
      bufWord_q  <= bufWord_d;
    end
  end

  // Dictionary RAM is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (state_q == DICT) begin
      if (kind_q == K_DICT) begin
        for (int b = 0; b < 4; b++) begin
          if (dWstrb_q[b]) dict_q[ramIdx][8*b +: 8] <= dWdata_q[8*b +: 8];
        end
      end
      ramRd_q <= dict_q[ramIdx];
    end
  end

  assign cpu_rdata = ramSel_q ? ramRd_q : rdata_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_wstrb = memWstrb_q;

endmodule

// File: tb/tb_code_expander.sv
// Directed self-checking bench for code_expander with a one-wait-state mem responder.
module tb_code_expander;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_valid, cpu_instr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  int compareCnt = 0;
  int failCnt = 0;

  int          memReqs = 0;
  bit          memPending = 1'b0;
  logic [31:0] lastAddr = 32'h0, lastWdata = 32'h0, memWord;
  logic [3:0]  lastWstrb = 4'h0;
  logic [31:0] memArr [logic [31:0]];

  logic [31:0] rd;
  int          lat, reqs;

  always #5 clk = ~clk;

  code_expander dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  // mem answers with a one-cycle ready pulse in the second cycle mem_valid is seen.
  always @(negedge clk) begin
    if (mem_ready) begin
      mem_ready  = 1'b0;
      memPending = 1'b0;
    end else if (mem_valid) begin
      if (memPending) begin
        lastAddr  = mem_addr;
        lastWstrb = mem_wstrb;
        lastWdata = mem_wdata;
        memReqs++;
        memWord = memArr.exists(mem_addr) ? memArr[mem_addr] : 32'h0;
        if (mem_wstrb != 4'h0) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) memWord[8*b +: 8] = mem_wdata[8*b +: 8];
          memArr[mem_addr] = memWord;
          mem_rdata = 32'h0;
        end else begin
          mem_rdata = memWord;
        end
        mem_ready = 1'b1;
      end else begin
        memPending = 1'b1;
      end
    end else begin
      memPending = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle; latency counts cycles from acceptance.
  task automatic applyStimulus(input string tag, input logic instr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               output logic [31:0] rdata, output int latency, output int nReqs);
    int startReqs;
    bit done;
    bit overlap;
    startReqs = memReqs;
    done      = 1'b0;
    overlap   = 1'b0;
    latency   = 0;
    cpu_valid = 1'b1;
    cpu_instr = instr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wstrb = wstrb;
    while (!done && latency < 40) begin
      @(negedge clk);
      latency++;
      if (mem_valid && cpu_ready) overlap = 1'b1;
      if (cpu_ready) done = 1'b1;
    end
    rdata     = cpu_rdata;
    cpu_valid = 1'b0;
    cpu_instr = 1'b0;
    cpu_wstrb = 4'h0;
    @(negedge clk);
    nReqs = memReqs - startReqs;
    checkOutput({tag, " completed"}, 32'(done), 32'd1);
    checkOutput({tag, " valid/ready overlap"}, 32'(overlap), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    cpu_valid = 1'b0;
    cpu_instr = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_wstrb = 4'h0;
    memArr[32'h0010_0000] = 32'hDEAD_BEEF;
    memArr[32'h0008_0000] = 32'h0007_0005;
    memArr[32'h0008_0004] = 32'h1234_0009;
    memArr[32'h0001_0000] = 32'h1111_1111;
    memArr[32'h2000_0400] = 32'h2222_2222;

    repeat (2) @(negedge clk);
    checkOutput("reset mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("reset cpu_rdata", cpu_rdata, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset mem_wstrb", 32'(mem_wstrb), 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] pass-through read");
    applyStimulus("pass rd", 1'b0, 32'h0010_0000, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("pass rd data", rd, 32'hDEAD_BEEF);
    checkOutput("pass rd latency", 32'(lat), 32'd3);
    checkOutput("pass rd mem reqs", 32'(reqs), 32'd1);
    checkOutput("pass rd mem_addr", lastAddr, 32'h0010_0000);
    checkOutput("pass rd mem_wstrb", 32'(lastWstrb), 32'h0);

    $display("[TB] dictionary writes and read");
    applyStimulus("dict wr 5", 1'b0, 32'h2000_0014, 32'h00A0_0093, 4'hF, rd, lat, reqs);
    checkOutput("dict wr latency", 32'(lat), 32'd2);
    checkOutput("dict wr mem reqs", 32'(reqs), 32'd0);
    applyStimulus("dict wr 7", 1'b0, 32'h2000_001C, 32'h00B0_0113, 4'hF, rd, lat, reqs);
    applyStimulus("dict wr 9", 1'b0, 32'h2000_0024, 32'h00C0_0193, 4'hF, rd, lat, reqs);
    applyStimulus("dict wr 2", 1'b0, 32'h2000_0008, 32'h00D0_0213, 4'hF, rd, lat, reqs);
    applyStimulus("dict rd 5", 1'b0, 32'h2000_0014, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("dict rd 5 data", rd, 32'h00A0_0093);
    checkOutput("dict rd latency", 32'(lat), 32'd2);

    $display("[TB] compressed fetch pair");
    applyStimulus("fetch 0x0", 1'b1, 32'h0000_0000, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("fetch 0x0 data", rd, 32'h00A0_0093);
    checkOutput("fetch 0x0 latency", 32'(lat), 32'd4);
    checkOutput("fetch 0x0 mem reqs", 32'(reqs), 32'd1);
    checkOutput("fetch 0x0 cw addr", lastAddr, 32'h0008_0000);
    applyStimulus("fetch 0x4", 1'b1, 32'h0000_0004, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("fetch 0x4 data", rd, 32'h00B0_0113);
    checkOutput("fetch 0x4 latency", 32'(lat), 32'd2);
    checkOutput("fetch 0x4 mem reqs", 32'(reqs), 32'd0);

    $display("[TB] retag and out-of-range index");
    applyStimulus("fetch 0x8", 1'b1, 32'h0000_0008, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("fetch 0x8 data", rd, 32'h00C0_0193);
    checkOutput("fetch 0x8 latency", 32'(lat), 32'd4);
    checkOutput("fetch 0x8 cw addr", lastAddr, 32'h0008_0004);
    applyStimulus("fetch 0xC", 1'b1, 32'h0000_000E, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("fetch 0xC nop", rd, 32'h0000_0013);
    checkOutput("fetch 0xC latency", 32'(lat), 32'd2);
    checkOutput("fetch 0xC mem reqs", 32'(reqs), 32'd0);
    applyStimulus("refetch 0x8", 1'b1, 32'h0000_0008, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("refetch 0x8 latency", 32'(lat), 32'd2);

    $display("[TB] byte-lane dictionary write");
    applyStimulus("dict wr lane1", 1'b0, 32'h2000_0014, 32'h0000_FF00, 4'h2, rd, lat, reqs);
    applyStimulus("dict rd merged", 1'b0, 32'h2000_0014, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("dict merged data", rd, 32'h00A0_FF93);

    $display("[TB] coherence on pass write");
    applyStimulus("fetch 0x0 again", 1'b1, 32'h0000_0000, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("fetch 0x0 again data", rd, 32'h00A0_FF93);
    checkOutput("fetch 0x0 again latency", 32'(lat), 32'd4);
    applyStimulus("fetch 0x4 buffered", 1'b1, 32'h0000_0004, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("fetch 0x4 buffered latency", 32'(lat), 32'd2);
    applyStimulus("pass wr", 1'b0, 32'h0008_0000, 32'hAAAA_0002, 4'h3, rd, lat, reqs);
    checkOutput("pass wr latency", 32'(lat), 32'd3);
    checkOutput("pass wr mem_addr", lastAddr, 32'h0008_0000);
    checkOutput("pass wr mem_wstrb", 32'(lastWstrb), 32'h3);
    checkOutput("pass wr mem_wdata", lastWdata, 32'hAAAA_0002);
    checkOutput("pass wr merged word", memArr[32'h0008_0000], 32'h0007_0002);
    applyStimulus("fetch after wr", 1'b1, 32'h0000_0000, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("fetch after wr data", rd, 32'h00D0_0213);
    checkOutput("fetch after wr latency", 32'(lat), 32'd4);
    checkOutput("fetch after wr mem reqs", 32'(reqs), 32'd1);

    $display("[TB] window boundaries");
    applyStimulus("fetch past window", 1'b1, 32'h0001_0000, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("past window data", rd, 32'h1111_1111);
    checkOutput("past window latency", 32'(lat), 32'd3);
    checkOutput("past window mem_addr", lastAddr, 32'h0001_0000);
    applyStimulus("dict past end", 1'b0, 32'h2000_0400, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("dict past end data", rd, 32'h2222_2222);
    checkOutput("dict past end mem_addr", lastAddr, 32'h2000_0400);

    $display("[TB] reset during mem access");
    cpu_valid = 1'b1;
    cpu_instr = 1'b0;
    cpu_addr  = 32'h0010_0000;
    cpu_wstrb = 4'h0;
    @(negedge clk);
    checkOutput("mid mem_valid before reset", 32'(mem_valid), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("mid reset mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("mid reset cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("mid reset mem_addr", mem_addr, 32'h0);
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    applyStimulus("fetch after reset", 1'b1, 32'h0000_0000, 32'h0, 4'h0, rd, lat, reqs);
    checkOutput("fetch after reset data", rd, 32'h00D0_0213);
    checkOutput("fetch after reset latency", 32'(lat), 32'd4);
    checkOutput("fetch after reset mem reqs", 32'(reqs), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
    $finish;
  end

endmodule
